// File: rtl/convolutional_encoder.sv
// K=7 (133,171 octal) convolutional encoder, rates 1/2, 2/3, 3/4.
// Define TAIL_INSERT_EN to flush six zero tail bits after In_Last.
module convolutional_encoder (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_input,
  input  logic       i_in_valid,
  input  logic       i_in_last,
  output logic       o_in_ready,
  input  logic [1:0] i_rate,
  output logic       o_output,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_TAIL
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [6:1] r_sr;
  logic [1:0] r_phase;
  logic [1:0] r_rate;
  logic [1:0] r_pair;
  logic       r_n;
  logic       r_idx;
  logic       r_last_seen;
`ifdef TAIL_INSERT_EN
  logic [2:0] r_tail_cnt;
`endif

  logic       w_accept;
  logic       w_enc;
  logic       w_bit;
  logic [1:0] w_rate;
  logic [1:0] w_phase;
  logic [1:0] w_phase_nxt;
  logic       w_a;
  logic       w_b;
  logic       w_keep_a;
  logic       w_keep_b;
  logic       w_grp_end;
  logic       w_tail_done;
  logic       w_frame_done;
  logic       w_out_hs;

  assign w_accept = o_in_ready & i_in_valid;
  assign w_enc    = w_accept | (r_state == S_TAIL);
  assign w_bit    = (r_state == S_TAIL) ? 1'b0 : i_input;
  assign w_rate   = (r_state == S_IDLE) ? i_rate : r_rate;
  assign w_phase  = (r_state == S_IDLE) ? 2'd0 : r_phase;

  assign w_a = w_bit ^ r_sr[2] ^ r_sr[3] ^ r_sr[5] ^ r_sr[6];
  assign w_b = w_bit ^ r_sr[1] ^ r_sr[2] ^ r_sr[3] ^ r_sr[6];

`ifdef TAIL_INSERT_EN
  assign w_tail_done = (r_tail_cnt == 3'd6);
`else
  assign w_tail_done = 1'b1;
`endif

  assign w_grp_end    = (r_idx == r_n);
  assign w_frame_done = r_last_seen & w_tail_done;
  assign w_out_hs     = (r_state == S_EMIT) & i_out_ready;

  // Puncture pattern and next phase for the bit being encoded
  always_comb begin
    w_keep_a    = 1'b1;
    w_keep_b    = 1'b1;
    w_phase_nxt = 2'd0;
    unique case (w_rate)
      2'b01: begin
        w_keep_b    = (w_phase == 2'd0);
        w_phase_nxt = (w_phase == 2'd1) ? 2'd0 : 2'd1;
      end
      2'b10: begin
        w_keep_a    = (w_phase != 2'd2);
        w_keep_b    = (w_phase != 2'd1);
        w_phase_nxt = (w_phase == 2'd2) ? 2'd0 : w_phase + 2'd1;
      end
      default: begin
        w_keep_a    = 1'b1;
        w_keep_b    = 1'b1;
        w_phase_nxt = 2'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (i_out_ready && w_grp_end) begin
          if (!r_last_seen)      w_next = S_LOAD;
          else if (!w_tail_done) w_next = S_TAIL;
          else                   w_next = S_IDLE;
        end
      end
      S_TAIL: w_next = S_EMIT;
      default: w_next = S_IDLE;
    endcase
  end

  // Encoder datapath: shift register, phase, retained coded bits
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sr        <= '0;
      r_phase     <= '0;
      r_rate      <= '0;
      r_pair      <= '0;
      r_n         <= 1'b0;
      r_idx       <= 1'b0;
      r_last_seen <= 1'b0;
`ifdef TAIL_INSERT_EN
      r_tail_cnt  <= '0;
`endif
    end else if (w_enc) begin
      r_sr    <= {r_sr[5:1], w_bit};
      r_phase <= w_phase_nxt;
      r_pair  <= w_keep_a ? {w_b, w_a} : {1'b0, w_b};
      r_n     <= w_keep_a & w_keep_b;
      r_idx   <= 1'b0;
      if (r_state == S_IDLE) r_rate <= i_rate;
      if (w_accept) r_last_seen <= i_in_last;
`ifdef TAIL_INSERT_EN
      if (r_state == S_TAIL) r_tail_cnt <= r_tail_cnt + 3'd1;
      else                   r_tail_cnt <= '0;
`endif
    end else if (w_out_hs) begin
      if (!w_grp_end) begin
        r_idx <= 1'b1;
      end else if (w_frame_done) begin
        r_sr        <= '0;
        r_phase     <= '0;
        r_last_seen <= 1'b0;
`ifdef TAIL_INSERT_EN
        r_tail_cnt  <= '0;
`endif
      end
    end
  end

  // Output decode
  always_comb begin
    o_in_ready  = ((r_state == S_IDLE) || (r_state == S_LOAD)) && !i_reset;
    o_out_valid = (r_state == S_EMIT);
    o_output    = (r_state == S_EMIT) && r_pair[r_idx];
    o_out_last  = (r_state == S_EMIT) && w_grp_end && w_frame_done;
  end

endmodule

// File: tb/tb_convolutional_encoder.sv
// Bench for convolutional_encoder: directed plus random frames
// checked against a generator-polynomial reference model.
module tb_convolutional_encoder;

`ifdef TAIL_INSERT_EN
  localparam int TAIL = 6;
`else
  localparam int TAIL = 0;
`endif
  localparam logic [6:0] G_A = 7'b1011011;
  localparam logic [6:0] G_B = 7'b1111001;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] rate;
  logic       dout;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int tests = 0;
  int fails = 0;

  logic bits[0:63];
  logic exp_q[$];
  logic obs_q[$];

  convolutional_encoder dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_input    (din),
    .i_in_valid (in_valid),
    .i_in_last  (in_last),
    .o_in_ready (in_ready),
    .i_rate     (rate),
    .o_output   (dout),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int n, input logic [1:0] r);
    int per;
    int ph;
    logic [6:0] win;
    logic a;
    logic b;
    exp_q.delete();
    per = (r == 2'b01) ? 2 : (r == 2'b10) ? 3 : 1;
    for (int t = 0; t < n + TAIL; t++) begin
      for (int k = 0; k < 7; k++)
        win[6-k] = (t - k >= 0 && t - k < n) ? bits[t-k] : 1'b0;
      a  = ^(win & G_A);
      b  = ^(win & G_B);
      ph = t % per;
      if (!(per == 3 && ph == 2)) exp_q.push_back(a);
      if (ph != 1) exp_q.push_back(b);
    end
  endtask

  // rmode: 0 always ready, 1 random ready/valid, 2 five-cycle stall
  task automatic run_frame(input int n, input logic [1:0] r0,
                           input logic [1:0] r1, input int rmode);
    int sent;
    int got;
    int cyc;
    bit stall_prev;
    logic po;
    logic pl;
    build_exp(n, r0);
    obs_q.delete();
    sent = 0; got = 0; cyc = 0; stall_prev = 0; po = 0; pl = 0;
    while (got < exp_q.size() && cyc < 2000) begin
      @(negedge clk);
      case (rmode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = !(cyc >= 4 && cyc < 9);
        default: out_ready = 1'b1;
      endcase
      if (sent < n) begin
        in_valid = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        din      = bits[sent];
        in_last  = (sent == n - 1);
        rate     = (sent == 0) ? r0 : r1;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        din      = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_out", 32'(dout), 32'(po));
        check("hold_last", 32'(out_last), 32'(pl));
      end
      if (out_valid) check("busy_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        obs_q.push_back(dout);
        check($sformatf("bit%0d", got), 32'(dout), 32'(exp_q[got]));
        check($sformatf("last%0d", got), 32'(out_last),
              32'(got == exp_q.size() - 1));
        got++;
      end
      if (in_valid && in_ready) sent++;
      stall_prev = out_valid && !out_ready;
      po = dout;
      pl = out_last;
      cyc++;
    end
    if (cyc >= 2000) check("timeout", 32'(got), 32'(exp_q.size()));
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_valid", 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] pack_obs();
    logic [31:0] v = '0;
    foreach (obs_q[i]) v = {v[30:0], obs_q[i]};
    return v;
  endfunction

  initial begin
    reset = 1'b1; din = 0; in_valid = 0; in_last = 0;
    rate = 2'b00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_out", 32'(dout), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // impulse, rate 1/2
    bits[0] = 1'b1;
    run_frame(1, 2'b00, 2'b00, 0);
`ifdef TAIL_INSERT_EN
    check("impulse_stream", pack_obs(), 32'b11011111001011);
`else
    check("impulse_stream", pack_obs(), 32'b11);
`endif

    // 12 zeros at rate 3/4
    for (int i = 0; i < 12; i++) bits[i] = 1'b0;
    run_frame(12, 2'b10, 2'b10, 0);
    check("r34_count", 32'(obs_q.size()), 32'(TAIL ? 24 : 16));

    // 1,0 at rate 2/3
    bits[0] = 1'b1; bits[1] = 1'b0;
    run_frame(2, 2'b01, 2'b01, 0);
    check("r23_head", 32'({obs_q[0], obs_q[1], obs_q[2]}), 32'b110);
    check("r23_count", 32'(obs_q.size()), 32'(TAIL ? 12 : 3));

    // backpressure on impulse
    bits[0] = 1'b1;
    run_frame(1, 2'b00, 2'b00, 2);
`ifdef TAIL_INSERT_EN
    check("bp_stream", pack_obs(), 32'b11011111001011);
`endif

    // reset during EMIT
    @(negedge clk);
    din = 1'b1; in_valid = 1'b1; in_last = 1'b1; rate = 2'b00;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("pre_rst_emit", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    check("abandon_valid", 32'(out_valid), 32'd0);
    bits[0] = 1'b1;
    run_frame(1, 2'b00, 2'b00, 0);
`ifdef TAIL_INSERT_EN
    check("rst_impulse", pack_obs(), 32'b11011111001011);
`else
    check("rst_impulse", pack_obs(), 32'b11);
`endif

    // rate change mid-frame ignored, next frame uses new rate
    for (int i = 0; i < 8; i++) bits[i] = 1'($urandom_range(0, 1));
    run_frame(8, 2'b00, 2'b10, 0);
    for (int i = 0; i < 6; i++) bits[i] = 1'($urandom_range(0, 1));
    run_frame(6, 2'b10, 2'b10, 0);

    // rate 11 behaves as 1/2
    for (int i = 0; i < 5; i++) bits[i] = 1'($urandom_range(0, 1));
    run_frame(5, 2'b11, 2'b11, 0);

    // random frames with random handshakes
    for (int f = 0; f < 25; f++) begin
      int n;
      logic [1:0] r;
      n = $urandom_range(1, 24);
      r = 2'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) bits[i] = 1'($urandom_range(0, 1));
      run_frame(n, r, 2'($urandom_range(0, 3)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/convolutional_encoder.md
CONVOLUTIONAL_ENCODER -- requirements
Module: convolutional_encoder

Interface
REQ-001 Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on Clock rising edge.
REQ-003 Input  input  1  uncoded data bit, qualified by In_Valid.
REQ-004 In_Valid  input  1  Input/In_Last valid this cycle.
REQ-005 In_Last  input  1  marks the final data bit of a frame.
REQ-006 In_Ready  output  1  block accepts Input this cycle; transfer = In_Valid & In_Ready.
REQ-007 Rate  input  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = treated as 1/2.
REQ-008 Output  output  1  coded bit, qualified by Out_Valid.
REQ-009 Out_Valid  output  1  Output valid; transfer = Out_Valid & Out_Ready.
REQ-010 Out_Ready  input  1  downstream accepts Output.
REQ-011 Out_Last  output  1  high with the final coded bit of a frame.

Function
REQ-012 Code: K = 7 with a 6-bit shift register s[1..6] (s1 newest); A = b^s2^s3^s5^s6 (133 octal), B = b^s1^s2^s3^s6 (171 octal), where b is the current input bit.
REQ-013 Emission order per input bit: A then B, subject to puncturing.
REQ-014 Puncture phase counter: cleared at frame start, advanced once per encoded bit including tail bits, wraps at 2 for rate 2/3 and at 3 for rate 3/4.
REQ-015 Rate 1/2: every bit emits A,B.
REQ-016 Rate 2/3: phase 0 emits A,B; phase 1 emits A only.
REQ-017 Rate 3/4: phase 0 emits A,B; phase 1 emits A only; phase 2 emits B only.
REQ-018 States:
- IDLE: In_Ready = 1. On accept, latch Rate, encode the bit, go to EMIT.
- LOAD: In_Ready = 1. Rate held. On accept, encode the bit, go to EMIT.
- EMIT: serialize the 1 or 2 retained coded bits; In_Ready = 0.
- TAIL: encode internally generated zero bits; In_Ready = 0.
REQ-019 Leaving EMIT after the last retained bit's handshake:
- to LOAD if the frame is not complete;
- to TAIL if In_Last was seen and tail bits remain;
- otherwise to IDLE, with the shift register cleared.
REQ-020 Latency: the first coded bit of an accepted input presents Out_Valid = 1 in the cycle after acceptance.
REQ-021 Out_Valid, Output and Out_Last hold stable while Out_Ready = 0.
REQ-022 No coded bit is dropped or duplicated under any Out_Ready pattern.
REQ-023 Rate changes after the first accepted bit of a frame are ignored until the next IDLE acceptance.
REQ-024 Out_Last asserts only on the final retained coded bit of the frame, including when puncturing ends the frame mid-group.
REQ-025 The puncture phase is not reset between data bits and tail bits.

Reset
REQ-026 While Reset = 1 at a rising edge, the block SHALL go to IDLE and clear:
- shift register, phase counter, latched rate;
- Output = 0, Out_Valid = 0, Out_Last = 0.
REQ-027 In_Ready = 0 while Reset = 1.
REQ-028 Reset mid-frame abandons the frame with no further coded bits; the next frame encodes from the all-zero state.

Configuration
REQ-029 Macro TAIL_INSERT_EN, when defined: after In_Last is accepted, the block SHALL encode 6 zero tail bits via TAIL, returning the encoder to state 0, with Out_Last on the final tail coded bit.
REQ-030 Without TAIL_INSERT_EN: no tail bits are generated; Out_Last is on the final coded bit of the In_Last input bit, and the shift register is cleared on return to IDLE.

Verification
REQ-031 Impulse, TAIL_INSERT_EN, rate 1/2, Out_Ready = 1: single bit 1 with In_Last -> 14 coded bits 11 01 11 11 00 10 11; Out_Last on bit 14.
REQ-032 Rate 3/4, no tail: 12 zero bits, last flagged -> exactly 16 coded bits, all 0; Out_Last on bit 16.
REQ-033 Rate 2/3, TAIL_INSERT_EN: bits 1,0 then Last -> 8 input bits produce 12 coded bits; bits 1-3 are 1,1,0 (A0 B0 A1).
REQ-034 Backpressure: Out_Ready held 0 for 5 cycles mid-frame -> Output/Out_Valid/Out_Last stable; In_Ready = 0; resumed stream bit-identical to the REQ-031 stream.
REQ-035 Reset asserted during EMIT -> next cycle Out_Valid = 0, In_Ready = 0; after release, repeating REQ-031 yields the identical 14-bit sequence.
REQ-036 Rate changed 00 -> 10 mid-frame -> frame continues at rate 1/2; the next frame uses 3/4.
